mbisr_repair_chain_ctrl: RTL

- Sequences a daisy chain of MBISR repair shift registers. Each segment has SEG_W bits, a negedge-retimed SO, a SE capture/shift select and a MSEL bypass.
- Two operations: capture-and-unload of repair data to a serial consumer, and serial load of repair data from a producer.
- Owns chain SE, clock enable and MSEL, so a stall never corrupts chain contents.
- Sits between the BISR controller/fuse interface and the per-memory repair registers.

---
 rtl/mbisr_chain_pkg.sv | 25 ++
 rtl/mbisr_chain_bitcnt.sv | 30 +++
 rtl/mbisr_repair_chain_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mbisr_chain_pkg.sv
// Shared types and helpers for the MBISR repair-chain controller.
// The RECIRC option is selected in the top file with MBISR_CHAIN_RECIRC_EN.
package mbisr_chain_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      CAPTURE,
      SHIFT,
      DONE
   } state_e;

   localparam logic MODE_UNLOAD = 1'b0;
   localparam logic MODE_LOAD   = 1'b1;

   function automatic int unsigned popcount(input logic [31:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < 32; i++) begin
         n = n + 32'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/mbisr_chain_bitcnt.sv
// Loadable bit down-counter: holds the remaining chain length of the
// current operation and flags the final and the exhausted count.
module mbisr_chain_bitcnt #(
   parameter int CNT_W = 7
) (
   input  logic             CLK,
   input  logic             RSTB,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             last,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign last = (cnt == CNT_W'(1));
   assign zero = (cnt == '0);

endmodule

// File: rtl/mbisr_repair_chain_ctrl.sv
// Sequences capture/unload and serial load of an MBISR repair-register chain.
// Define MBISR_CHAIN_RECIRC_EN to recirculate SO into SI during unload.
module mbisr_repair_chain_ctrl
   import mbisr_chain_pkg::*;
#(
   parameter int NUM_SEG = 4,
   parameter int SEG_W   = 22,
   parameter int CNT_W   = $clog2(NUM_SEG*SEG_W+1)
) (
   input  logic               CLK,
   input  logic               RSTB,
   input  logic               start,
   input  logic               mode,
   input  logic [NUM_SEG-1:0] seg_en,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic               chain_se,
   output logic               chain_clk_en,
   output logic [NUM_SEG-1:0] chain_msel,
   output logic               chain_si,
   input  logic               chain_so,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_data,
   output state_e             dbg_state
);

   state_e             state;
   logic               mode_q;
   logic [NUM_SEG-1:0] seg_en_q;
   logic               xfer;
   logic               cnt_last;
   logic               cnt_zero;
   logic [CNT_W-1:0]   len;

   // A bit moves only on valid && ready; ready/valid are raised only in SHIFT,
   // so a missing partner simply gates the chain clock and freezes the chain.
   assign xfer         = (in_valid & in_ready) | (out_valid & out_ready);
   assign chain_clk_en = (state == CAPTURE) | xfer;
   assign out_data     = out_valid & chain_so;
`ifdef MBISR_CHAIN_RECIRC_EN
   assign chain_si     = in_ready ? in_data : (out_valid & chain_so);
`else
   assign chain_si     = in_ready & in_data;
`endif
   assign len          = CNT_W'(popcount(32'(seg_en_q)) * SEG_W);
   assign dbg_state    = state;

   mbisr_chain_bitcnt #(
      .CNT_W (CNT_W)
   ) u_bitcnt (
      .CLK      (CLK),
      .RSTB     (RSTB),
      .load     (state == SETUP),
      .load_val (len),
      .dec      (xfer),
      .last     (cnt_last),
      .zero     (cnt_zero)
   );

   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         state      <= IDLE;
         mode_q     <= MODE_UNLOAD;
         seg_en_q   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         chain_se   <= 1'b1;
         chain_msel <= '1;
         in_ready   <= 1'b0;
         out_valid  <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (seg_en == '0) begin
                     err <= 1'b1;
                  end else begin
                     mode_q     <= mode;
                     seg_en_q   <= seg_en;
                     chain_msel <= ~seg_en;
                     busy       <= 1'b1;
                     state      <= SETUP;
                  end
               end
            end
            SETUP: begin
               if (mode_q == MODE_LOAD) begin
                  in_ready <= 1'b1;
                  state    <= SHIFT;
               end else begin
                  chain_se <= 1'b0;
                  state    <= CAPTURE;
               end
            end
            CAPTURE: begin
               chain_se  <= 1'b1;
               out_valid <= 1'b1;
               state     <= SHIFT;
            end
            SHIFT: begin
               // cnt_zero is a guard only; the count is never empty here.
               if ((xfer && cnt_last) || cnt_zero) begin
                  in_ready  <= 1'b0;
                  out_valid <= 1'b0;
                  done      <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
